// File: rtl/rv32_bus_pkg.sv
// rv32_bus_pkg: shared types and widths for the rv32 instruction/data bus arbiter
package rv32_bus_pkg;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;
    typedef enum logic {SRC_I, SRC_D} src_t;
endpackage

// File: rtl/rv32_bus_arbiter.sv
// rv32_bus_arbiter: merges the rv32 fetch and data buses onto one memory bus, data first with a fetch starvation guard
// Optional grant/wait statistics counters are enabled by defining RV32_BUS_ARBITER_STATS_EN.
module rv32_bus_arbiter
    import rv32_bus_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] instr_address_in,
    input  logic                  instr_read_in,
    output logic [DATA_W-1:0]     instr_read_value_out,
    output logic                  instr_ready_out,
    input  logic [ADDR_WIDTH-1:0] data_address_in,
    input  logic                  data_read_in,
    input  logic                  data_write_in,
    input  logic [MASK_W-1:0]     data_write_mask_in,
    input  logic [DATA_W-1:0]     data_write_value_in,
    output logic [DATA_W-1:0]     data_read_value_out,
    output logic                  data_ready_out,
    output logic [ADDR_WIDTH-1:0] mem_address_out,
    output logic                  mem_read_out,
    output logic                  mem_write_out,
    output logic [MASK_W-1:0]     mem_write_mask_out,
    output logic [DATA_W-1:0]     mem_write_value_out,
    input  logic [DATA_W-1:0]     mem_read_value_in,
    input  logic                  mem_ready_in
`ifdef RV32_BUS_ARBITER_STATS_EN
    ,
    output logic [31:0]           stat_instr_grants_out,
    output logic [31:0]           stat_data_grants_out,
    output logic [31:0]           stat_wait_cycles_out
`endif
);
    localparam int SW = $clog2(MAX_DATA_STREAK + 1);

    state_t        state;
    logic [SW-1:0] streak;
    logic          data_req;
    src_t          src;

    always_comb begin
        data_req = data_read_in | data_write_in;
        // fetch wins only once it has watched MAX_DATA_STREAK data grants go by
        src = (data_req && (!instr_read_in || streak < SW'(MAX_DATA_STREAK))) ? SRC_D : SRC_I;
        instr_ready_out = (state == GRANT_I) && mem_ready_in;
        data_ready_out = (state == GRANT_D) && mem_ready_in;
        instr_read_value_out = instr_ready_out ? mem_read_value_in : '0;
        data_read_value_out = data_ready_out ? mem_read_value_in : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            streak <= '0;
            mem_address_out <= '0;
            mem_read_out <= 1'b0;
            mem_write_out <= 1'b0;
            mem_write_mask_out <= '0;
            mem_write_value_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (src == SRC_D) begin
                        state <= GRANT_D;
                        streak <= instr_read_in ? streak + 1'b1 : '0;
                        mem_address_out <= data_address_in;
                        mem_read_out <= data_read_in & ~data_write_in;
                        mem_write_out <= data_write_in;
                        mem_write_mask_out <= data_write_in ? data_write_mask_in : '0;
                        mem_write_value_out <= data_write_in ? data_write_value_in : '0;
                    end else if (instr_read_in) begin
                        state <= GRANT_I;
                        streak <= '0;
                        mem_address_out <= instr_address_in;
                        mem_read_out <= 1'b1;
                        mem_write_out <= 1'b0;
                        mem_write_mask_out <= '0;
                        mem_write_value_out <= '0;
                    end
                end
                default: begin
                    if (mem_ready_in) begin
                        state <= IDLE;
                        mem_address_out <= '0;
                        mem_read_out <= 1'b0;
                        mem_write_out <= 1'b0;
                        mem_write_mask_out <= '0;
                        mem_write_value_out <= '0;
                    end
                end
            endcase
        end
    end

`ifdef RV32_BUS_ARBITER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_instr_grants_out <= '0;
            stat_data_grants_out <= '0;
            stat_wait_cycles_out <= '0;
        end else begin
            if (state == IDLE && src == SRC_D)
                stat_data_grants_out <= stat_data_grants_out + 1;
            if (state == IDLE && src == SRC_I && instr_read_in)
                stat_instr_grants_out <= stat_instr_grants_out + 1;
            if ((instr_read_in && !instr_ready_out) || (data_req && !data_ready_out))
                stat_wait_cycles_out <= stat_wait_cycles_out + 1;
        end
    end
`endif
endmodule

// File: doc/rv32_bus_arbiter.md
Name: rv32_bus_arbiter

Overview:
Downstream neighbour of the rv32 core. Merges the core's separate instruction bus and data bus onto one shared memory bus (RAM, ROM and peripherals) using a registered grant FSM. Data requests have priority over instruction requests. A starvation counter guarantees that fetch makes forward progress.

Parameters:
MAX_DATA_STREAK, 4, consecutive data grants allowed while an instruction request waits; the next grant then goes to instruction
ADDR_WIDTH, 32, address width on both sides

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
instr_address_in  in  ADDR_WIDTH  core fetch address
instr_read_in  in  1  core fetch request
instr_read_value_out  out  32  fetch data
instr_ready_out  out  1  fetch complete
data_address_in  in  ADDR_WIDTH  core data address
data_read_in  in  1  core load request
data_write_in  in  1  core store request
data_write_mask_in  in  4  byte enables
data_write_value_in  in  32  store data
data_read_value_out  out  32  load data
data_ready_out  out  1  data access complete
mem_address_out  out  ADDR_WIDTH  shared bus address
mem_read_out  out  1  shared bus read strobe
mem_write_out  out  1  shared bus write strobe
mem_write_mask_out  out  4  byte enables (0 on reads)
mem_write_value_out  out  32  write data
mem_read_value_in  in  32  read data
mem_ready_in  in  1  slave completion

Behaviour:
- Reset values:
  - all mem_* outputs 0; both ready outputs 0; FSM IDLE; streak counter 0.
  - Reset mid-transaction abandons the access. mem strobes drop the cycle after reset is asserted.
- Master rule: a master holds its request and operands stable until its ready pulse. The arbiter never samples a request twice.
- FSM states: IDLE, GRANT_I, GRANT_D.
- IDLE:
  - data request (read|write) pending and (instr not pending or streak<MAX_DATA_STREAK) -> GRANT_D. Register data address/strobes/mask/value onto mem_*. If instr is pending, streak++; otherwise streak=0.
  - otherwise, instr_read_in -> GRANT_I. Register instr address, mem_read_out=1, mask=0. streak=0.
  - otherwise, stay in IDLE.
- GRANT_x waits for mem_ready_in. On the ready cycle:
  - x_ready_out=1 combinationally. Read value passed straight from mem_read_value_in.
  - mem strobes cleared at the next edge; FSM -> IDLE.
- Latency: request at cycle N -> mem strobe at N+1 -> earliest ready at N+1. One dead IDLE cycle follows each access.
- Simultaneous data read+write asserted: treated as a write. mem_read_out=0.
- Ungranted master: its ready output stays 0. Its value output is 0 whenever its ready is 0.
- The streak counter saturates at MAX_DATA_STREAK and is cleared by any instruction grant.

Optional Feature:
RV32_BUS_ARBITER_STATS_EN: adds outputs stat_instr_grants_out[31:0], stat_data_grants_out[31:0] and stat_wait_cycles_out[31:0].
- stat_wait_cycles_out counts cycles in which any request is pending and not being completed. Counters wrap modulo 2^32 and reset to 0.
- Without the macro, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package rv32_bus_pkg: FSM state enum, the grant-source typedef and the bus field widths.
- No sub-module. Optionally a tiny rv32_bus_arbiter_stats counter block when the feature is enabled.

Test Plan:
- Instr read 0x100 only, slave ready 1 cycle later -> mem_read_out at N+1 with addr 0x100; instr_ready_out=1 with value 0xDEADBEEF; back to IDLE.
- Instr and data write 0x2000/mask 0b0011 at the same cycle -> data granted first (mem_write_out=1, mask 0011); instr granted after the data ready.
- Continuous data reads with instr pending, MAX_DATA_STREAK=4 -> exactly 4 data grants, then 1 instr grant, then the streak resets.
- Reset asserted while GRANT_D waits (mem_ready_in held 0) -> all mem strobes 0 next cycle, no ready pulse, FSM IDLE.
- Data read+write both high -> mem_write_out=1, mem_read_out=0; data_read_value_out=0 except on the ready cycle.
- With RV32_BUS_ARBITER_STATS_EN: 3 instr and 2 data accesses, 1-cycle slave -> grants counters 3/2; wait counter matches a scoreboard count.
